nios_qsys_led_blinker: RTL and testbench

- Avalon-MM slave PWM/blink generator, directly downstream of the 1-bit output PIO.
- The PIO's out_port drives enable_in and gates the generator on and off.
- The Nios processor programs period, on-time, polarity and interrupt behaviour through four 32-bit registers.
- led_out drives a board LED; the block raises an optional per-period interrupt.

---
 rtl/nios_qsys_led_blinker.sv | 172 +++++++++++++++++
 tb/tb_nios_qsys_led_blinker.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/nios_qsys_led_blinker.sv
// Avalon-MM programmable PWM/blink generator placed behind the 1-bit LED PIO.
// The CPU programs period/on-time shadows; a RUN/IDLE FSM produces led_out and a per-period pulse.
module nios_qsys_led_blinker #(
  parameter int          CNT_W          = 32,
  parameter int unsigned DEFAULT_PERIOD = 50000000,
  parameter int unsigned DEFAULT_ON     = 25000000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic        enable_in,
  output logic        led_out,
  output logic        period_done,
  output logic        irq
);

  localparam logic [CNT_W-1:0] RST_PERIOD = CNT_W'(DEFAULT_PERIOD);
  localparam logic [CNT_W-1:0] RST_ON     = CNT_W'(DEFAULT_ON);
  localparam logic [CNT_W-1:0] MIN_PERIOD = CNT_W'(2);
  localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] period_act_reg;
  logic [CNT_W-1:0] on_act_reg;
  logic [CNT_W-1:0] period_sh_reg;
  logic [CNT_W-1:0] on_sh_reg;
  logic             sw_en_reg;
  logic             invert_reg;
  logic             irq_en_reg;
  logic             led_reg;
  logic             period_done_reg;
  logic             flag_reg;

  logic             wr_en;
  logic [CNT_W-1:0] wr_data;
  logic [CNT_W-1:0] period_wr_val;
  logic             run;
  logic [CNT_W-1:0] cnt_inc;
  logic             cnt_last;
  logic             shadow_on_nonzero;
  logic [31:0]      period_rd;
  logic [31:0]      on_rd;

  assign wr_en             = chipselect & ~write_n;
  assign wr_data           = writedata[CNT_W-1:0];
  assign period_wr_val     = (wr_data < MIN_PERIOD) ? MIN_PERIOD : wr_data;
  assign run               = enable_in & sw_en_reg;
  assign cnt_inc           = cnt_reg + ONE;
  assign cnt_last          = (cnt_reg == (period_act_reg - ONE));
  assign shadow_on_nonzero = (on_sh_reg != '0);

  // CPU-visible registers; the flag set from a pulse beats a same-cycle clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sw_en_reg     <= 1'b1;
      invert_reg    <= 1'b0;
      irq_en_reg    <= 1'b0;
      period_sh_reg <= RST_PERIOD;
      on_sh_reg     <= RST_ON;
      flag_reg      <= 1'b0;
    end else begin
      if (wr_en) begin
        case (address)
          2'd0: begin
            sw_en_reg  <= writedata[0];
            invert_reg <= writedata[1];
            irq_en_reg <= writedata[2];
          end
          2'd1: period_sh_reg <= period_wr_val;
          2'd2: on_sh_reg     <= wr_data;
          default: ;
        endcase
      end
      if (period_done_reg) begin
        flag_reg <= 1'b1;
      end else if (wr_en && (address == 2'd3)) begin
        flag_reg <= 1'b0;
      end
    end
  end

  // Blink FSM: led_out is computed from the counter value of the cycle being entered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg       <= IDLE;
      cnt_reg         <= '0;
      period_act_reg  <= RST_PERIOD;
      on_act_reg      <= RST_ON;
      led_reg         <= 1'b0;
      period_done_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          cnt_reg         <= '0;
          period_done_reg <= 1'b0;
          if (run) begin
            state_reg      <= RUN;
            period_act_reg <= period_sh_reg;
            on_act_reg     <= on_sh_reg;
            led_reg        <= shadow_on_nonzero ^ invert_reg;
          end else begin
            led_reg <= invert_reg;
          end
        end
        RUN: begin
          if (!run) begin
            state_reg       <= IDLE;
            cnt_reg         <= '0;
            led_reg         <= invert_reg;
            period_done_reg <= 1'b0;
          end else if (cnt_last) begin
            cnt_reg         <= '0;
            period_act_reg  <= period_sh_reg;
            on_act_reg      <= on_sh_reg;
            period_done_reg <= 1'b1;
            led_reg         <= shadow_on_nonzero ^ invert_reg;
          end else begin
            cnt_reg         <= cnt_inc;
            period_done_reg <= 1'b0;
            led_reg         <= (cnt_inc < on_act_reg) ^ invert_reg;
          end
        end
        default: begin
          state_reg       <= IDLE;
          cnt_reg         <= '0;
          led_reg         <= invert_reg;
          period_done_reg <= 1'b0;
        end
      endcase
    end
  end

  // Zero-extend the shadow registers onto the 32-bit bus.
  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_rd
      if (gi < CNT_W) begin : g_bit
        assign period_rd[gi] = period_sh_reg[gi];
        assign on_rd[gi]     = on_sh_reg[gi];
      end else begin : g_pad
        assign period_rd[gi] = 1'b0;
        assign on_rd[gi]     = 1'b0;
      end
    end
  endgenerate

  always_comb begin
    readdata = '0;
    case (address)
      2'd0: readdata = {29'd0, irq_en_reg, invert_reg, sw_en_reg};
      2'd1: readdata = period_rd;
      2'd2: readdata = on_rd;
      2'd3: readdata = {30'd0, flag_reg, (state_reg == RUN)};
      default: readdata = '0;
    endcase
  end

  assign led_out     = led_reg;
  assign period_done = period_done_reg;
  assign irq         = flag_reg & irq_en_reg;

endmodule

// File: tb/tb_nios_qsys_led_blinker.sv
// Directed bench: expected led_out/period_done per cycle are queued with the stimulus
// and popped one entry per clock; register reads and irq are checked inline.
module tb_nios_qsys_led_blinker;

  localparam int          CNT_W  = 32;
  localparam int unsigned DEF_P  = 12;
  localparam int unsigned DEF_ON = 5;

  logic        clk;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        enable_in;
  logic        led_out;
  logic        period_done;
  logic        irq;

  typedef struct {
    logic led;
    logic pd;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passes = 0;
  int   cyc    = 0;

  nios_qsys_led_blinker #(
    .CNT_W         (CNT_W),
    .DEFAULT_PERIOD(DEF_P),
    .DEFAULT_ON    (DEF_ON)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .enable_in  (enable_in),
    .led_out    (led_out),
    .period_done(period_done),
    .irq        (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Bit n-1 of each vector is the first cycle.
  task automatic push_seq(input int n, input logic [63:0] leds, input logic [63:0] pds);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.led = leds[n-1-i];
      e.pd  = pds[n-1-i];
      sb.push_back(e);
    end
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk($sformatf("led_out@%0d", cyc), {31'd0, led_out}, {31'd0, e.led});
      chk($sformatf("period_done@%0d", cyc), {31'd0, period_done}, {31'd0, e.pd});
    end
  endtask

  task automatic run_ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wr_tick(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd_chk(input logic [1:0] a, input logic [31:0] exp, input string tag);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    #1;
    chk(tag, readdata, exp);
    chipselect = 1'b0;
  endtask

  initial begin
    reset_n    = 1'b0;
    enable_in  = 1'b0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = 2'd0;
    writedata  = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_led", {31'd0, led_out}, 32'd0);
    chk("rst_pd", {31'd0, period_done}, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    reset_n = 1'b1;
    rd_chk(2'd0, 32'h1, "rst_control");
    rd_chk(2'd1, DEF_P, "rst_period");
    rd_chk(2'd2, DEF_ON, "rst_on");
    rd_chk(2'd3, 32'h0, "rst_status");
    tick();

    // 1: period 4, on 1
    push_seq(3, 3'b000, 3'b000);
    wr_tick(2'd1, 32'd4);
    wr_tick(2'd2, 32'd1);
    wr_tick(2'd0, 32'h1);
    enable_in = 1'b1;
    push_seq(8, 8'b1000_1000, 8'b0000_1000);
    tick();
    rd_chk(2'd3, 32'h1, "status_running");
    run_ticks(7);
    rd_chk(2'd3, 32'h3, "status_flag");

    // 2: shadows change mid-period, new timing only from the next period
    push_seq(11, 11'b10001110001, 11'b10001000001);
    tick();
    wr_tick(2'd1, 32'd6);
    wr_tick(2'd2, 32'd3);
    run_ticks(8);
    rd_chk(2'd1, 32'd6, "period_rb6");
    rd_chk(2'd2, 32'd3, "on_rb3");

    // 3: drop enable at cnt=2, then restart
    push_seq(2, 2'b11, 2'b00);
    run_ticks(2);
    enable_in = 1'b0;
    push_seq(2, 2'b00, 2'b00);
    tick();
    rd_chk(2'd3, 32'h2, "status_stopped");
    tick();
    enable_in = 1'b1;
    push_seq(3, 3'b111, 3'b000);
    run_ticks(3);

    // 4: invert + irq_en, clear races
    enable_in = 1'b0;
    push_seq(6, 6'b000001, 6'b000000);
    tick();
    wr_tick(2'd3, 32'd0);
    chk("irq_cleared", {31'd0, irq}, 32'd0);
    rd_chk(2'd3, 32'h0, "status_cleared");
    wr_tick(2'd1, 32'd4);
    wr_tick(2'd2, 32'd1);
    wr_tick(2'd0, 32'h7);
    tick();
    enable_in = 1'b1;
    push_seq(5, 5'b01110, 5'b00001);
    run_ticks(5);
    chk("irq_before_flag", {31'd0, irq}, 32'd0);
    push_seq(7, 7'b1110111, 7'b0001000);
    wr_tick(2'd3, 32'd0);
    chk("irq_set_wins", {31'd0, irq}, 32'd1);
    rd_chk(2'd3, 32'h3, "status_set_wins");
    wr_tick(2'd3, 32'd0);
    chk("irq_cpu_clear", {31'd0, irq}, 32'd0);
    run_ticks(3);
    chk("irq_second", {31'd0, irq}, 32'd1);
    wr_tick(2'd0, 32'h3);
    chk("irq_masked", {31'd0, irq}, 32'd0);
    rd_chk(2'd3, 32'h3, "flag_preserved");
    tick();

    // 5: period clamp, on_time 0 and on_time >= period
    push_seq(16, 16'b0111_1111_1100_0000, 16'b1000_1010_1010_0010);
    wr_tick(2'd1, 32'd0);
    rd_chk(2'd1, 32'd2, "period_clamp");
    wr_tick(2'd2, 32'd0);
    run_ticks(4);
    chk("irq_still_masked", {31'd0, irq}, 32'd0);
    rd_chk(2'd0, 32'h3, "control_rb3");
    run_ticks(2);
    wr_tick(2'd1, 32'd4);
    wr_tick(2'd2, 32'd5);
    run_ticks(6);

    // 6: asynchronous reset mid-period
    push_seq(3, 3'b011, 3'b001);
    wr_tick(2'd0, 32'h5);
    run_ticks(2);
    chk("pre_rst_irq", {31'd0, irq}, 32'd1);
    #1;
    reset_n = 1'b0;
    #1;
    chk("async_led", {31'd0, led_out}, 32'd0);
    chk("async_pd", {31'd0, period_done}, 32'd0);
    chk("async_irq", {31'd0, irq}, 32'd0);
    rd_chk(2'd1, DEF_P, "rst2_period");
    rd_chk(2'd0, 32'h1, "rst2_control");
    rd_chk(2'd2, DEF_ON, "rst2_on");
    push_seq(2, 2'b00, 2'b00);
    run_ticks(2);
    reset_n = 1'b1;
    push_seq(13, 13'b1111100000001, 13'b0000000000001);
    tick();
    rd_chk(2'd3, 32'h1, "status_restart");
    run_ticks(12);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
